// File: rtl/calc_display.sv
// calc_display: captures the core's serial BCD digit stream into a shadow
// buffer, commits full frames to an active buffer, and scans an 8-digit
// active-low seven-segment display with leading-zero blanking and a
// sticky "Erro" screen.
//
// Ports:
//   clock, reset         system clock, async active-high reset
//   status[1:0]          core status: 00 error, 01 busy, 10 ready
//   data[3:0], pos[3:0]  BCD digit value and its slot (0 = LSD)
//   an[7:0]              digit enables, active low, one-hot-zero
//   seg[6:0]             segments {g,f,e,d,c,b,a}, active low
//   dp                   decimal point, always off (1)
//   commit               one-cycle pulse when a frame goes active
module calc_display #(
   parameter int SCAN_DIV = 50000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] status,
   input  logic [3:0] data,
   input  logic [3:0] pos,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       commit
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRES_MAX = PW'(SCAN_DIV - 1);

   logic [7:0][3:0] shadow_q, shadow_d;
   logic [7:0][3:0] active_q, active_d;
   logic [7:0]      mask_q, mask_d;
   logic            err_q, err_d;
   logic [2:0]      idx_q, idx_d;
   logic [PW-1:0]   pres_q, pres_d;
   logic [7:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            commit_q, commit_d;

   logic            cap;
   logic            full;
   logic [7:0]      lz;
   logic [3:0]      sel;

   function automatic logic [6:0] digit_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'd0:    g = 7'h40;
         4'd1:    g = 7'h79;
         4'd2:    g = 7'h24;
         4'd3:    g = 7'h30;
         4'd4:    g = 7'h19;
         4'd5:    g = 7'h12;
         4'd6:    g = 7'h02;
         4'd7:    g = 7'h78;
         4'd8:    g = 7'h00;
         4'd9:    g = 7'h10;
         default: g = 7'h7F;
      endcase
      return g;
   endfunction

   function automatic logic [6:0] err_glyph(input logic [2:0] i);
      logic [6:0] g;
      case (i)
         3'd3:       g = 7'h06;
         3'd2, 3'd1: g = 7'h2F;
         3'd0:       g = 7'h23;
         default:    g = 7'h7F;
      endcase
      return g;
   endfunction

   // Capture and commit. The commit clears the mask first so a capture
   // on the same edge lands in the fresh mask and only in the shadow.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      mask_d   = mask_q;
      cap      = (status != 2'b10) && !pos[3];
      full     = (mask_q == 8'hFF);
      if (full) begin
         active_d = shadow_q;
         mask_d   = '0;
      end
      if (cap) begin
         shadow_d[pos[2:0]] = data;
         mask_d[pos[2:0]]   = 1'b1;
      end
      commit_d = full;
      err_d    = err_q | (status == 2'b00);
   end

   // Scan prescaler and digit index
   always_comb begin
      pres_d = pres_q + PW'(1);
      idx_d  = idx_q;
      if (pres_q == PRES_MAX) begin
         pres_d = '0;
         idx_d  = idx_q + 3'd1;
      end
   end

   // lz[i]: active digits i..7 are all zero
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         lz[i] = 1'b1;
         for (int j = i; j < 8; j++) begin
            if (active_q[j] != 4'd0) lz[i] = 1'b0;
         end
      end
   end

   always_comb begin
      sel  = active_q[idx_q];
      an_d = ~(8'h01 << idx_q);
      if (err_q)
         seg_d = err_glyph(idx_q);
      else if (BLANK_LZ && (idx_q != 3'd0) && lz[idx_q])
         seg_d = 7'h7F;
      else
         seg_d = digit_glyph(sel);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow_q <= '0;
         active_q <= '0;
         mask_q   <= '0;
         err_q    <= 1'b0;
         idx_q    <= '0;
         pres_q   <= '0;
         an_q     <= 8'hFF;
         seg_q    <= 7'h7F;
         commit_q <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         mask_q   <= mask_d;
         err_q    <= err_d;
         idx_q    <= idx_d;
         pres_q   <= pres_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         commit_q <= commit_d;
      end
   end

   assign an     = an_q;
   assign seg    = seg_q;
   assign dp     = 1'b1;
   assign commit = commit_q;

endmodule

// File: tb/tb_calc_display.sv
// tb_calc_display: directed frames for calc_display with a commit/scan
// scoreboard monitor.
module tb_calc_display;

   localparam int SD = 4;

   typedef logic [7:0][6:0] frame_t;
   typedef logic [7:0][3:0] digits_t;

   localparam frame_t F_ZERO = {{7{7'h7F}}, 7'h40};

   logic       clock  = 1'b0;
   logic       reset  = 1'b0;
   logic [1:0] status = 2'b10;
   logic [3:0] data   = 4'd0;
   logic [3:0] pos    = 4'd15;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       commit;

   calc_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
      .clock  (clock),
      .reset  (reset),
      .status (status),
      .data   (data),
      .pos    (pos),
      .an     (an),
      .seg    (seg),
      .dp     (dp),
      .commit (commit)
   );

   always #5 clock = ~clock;

   frame_t q[$];
   int     checks    = 0;
   int     errors    = 0;
   int     cyc       = 0;
   int     err_start = 32'h7FFFFFFF;
   logic   live      = 1'b0;

   always @(posedge clock) begin
      cyc  <= cyc + 1;
      live <= !reset;
   end

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [6:0] eglyph(input int i);
      logic [6:0] g;
      case (i)
         3:       g = 7'h06;
         2, 1:    g = 7'h2F;
         0:       g = 7'h23;
         default: g = 7'h7F;
      endcase
      return g;
   endfunction

   // Monitor: scan model plus expected-frame scoreboard
   frame_t     cur   = F_ZERO;
   int         midx  = 0;
   int         mpres = 0;
   logic [6:0] e;

   always @(negedge clock) begin
      if (reset) begin
         chk("rst_an", an, 8'hFF);
         chk("rst_seg", {1'b0, seg}, 8'h7F);
         chk("rst_commit", {7'd0, commit}, 8'h00);
         cur   = F_ZERO;
         midx  = 0;
         mpres = 0;
      end else if (live) begin
         chk("scan_an", an, ~(8'h01 << midx));
         e = (cyc >= err_start) ? eglyph(midx) : cur[midx];
         chk($sformatf("seg_d%0d", midx), {1'b0, seg}, {1'b0, e});
         chk("dp", {7'd0, dp}, 8'h01);
         if (commit) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL commit: got unexpected pulse expected none at cycle %0d",
                        cyc);
            end else begin
               cur = q.pop_front();
            end
         end
         mpres++;
         if (mpres == SD) begin
            mpres = 0;
            midx  = (midx + 1) % 8;
         end
      end
   end

   always @(posedge reset) begin
      #1;
      chk("async_an", an, 8'hFF);
      chk("async_seg", {1'b0, seg}, 8'h7F);
   end

   task automatic drv(input logic [1:0] s, input logic [3:0] p,
                      input logic [3:0] d);
      @(negedge clock);
      status = s;
      pos    = p;
      data   = d;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(2'b10, 4'd15, 4'd0);
   endtask

   task automatic frame(input digits_t v);
      for (int i = 0; i < 8; i++) drv(2'b01, 4'(i), v[i]);
   endtask

   initial begin
      int w;
      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      idle(40);

      // 3,2,1 with leading zeros blanked
      frame({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3});
      q.push_back({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30});
      idle(40);

      // partial frame, then ready-status inputs are ignored
      for (int i = 0; i < 5; i++) drv(2'b01, 4'(i), 4'd8);
      for (int k = 0; k < 100; k++) drv(2'b10, 4'(5 + k % 3), 4'd1);

      // all nines, then a back-to-back frame whose slot 0 lands on the commit edge
      frame({8{4'd9}});
      q.push_back({8{7'h10}});
      drv(2'b01, 4'd0, 4'd1);
      drv(2'b01, 4'd1, 4'd2);
      drv(2'b01, 4'd2, 4'd5);
      drv(2'b01, 4'd2, 4'd7);
      drv(2'b01, 4'd3, 4'd12);
      for (int p = 8; p < 16; p++) drv(2'b01, 4'(p), 4'd9);
      for (int p = 4; p < 8; p++) drv(2'b01, 4'(p), 4'd0);
      q.push_back({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h24, 7'h79});
      idle(40);

      // one error cycle, sticky through a later frame
      drv(2'b00, 4'd15, 4'd0);
      err_start = cyc + 2;
      idle(10);
      frame({4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1});
      q.push_back({7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});
      idle(40);

      // reset clears the error screen
      @(posedge clock);
      #1 reset = 1'b1;
      err_start = 32'h7FFFFFFF;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      idle(40);

      // reset mid-frame discards the captured slots
      for (int i = 0; i < 4; i++) drv(2'b01, 4'(i), 4'd8);
      @(posedge clock);
      #1 reset = 1'b1;
      status = 2'b10;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int p = 4; p < 8; p++) drv(2'b01, 4'(p), 4'(p - 3));
      idle(20);
      for (int p = 0; p < 3; p++) drv(2'b01, 4'(p), 4'd0);
      drv(2'b01, 4'd3, 4'd5);
      q.push_back({7'h19, 7'h30, 7'h24, 7'h79, 7'h12, 7'h40, 7'h40, 7'h40});
      idle(40);

      w = 0;
      while (q.size() != 0 && w < 200) begin
         @(negedge clock);
         w++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending commits expected 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_display.md
Name: calc_display

Overview:
- Downstream consumer of the calculator core's serial digit stream (status, data, pos).
- Captures the eight BCD digits the core emits, one per clock, into a shadow buffer, then commits a full frame to an active buffer.
- Drives an 8-digit multiplexed, active-low seven-segment display from the active buffer, with leading-zero blanking and a sticky "Erro" screen.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot in the multiplex scan (legal range 1 to 2^20-1)
BLANK_LZ, 1, 1 = blank leading zeros (digit 0 is never blanked); 0 = show all digits

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
status  in  2  core status: 00 error, 01 busy, 10 ready
data  in  4  BCD digit value for slot pos
pos  in  4  digit slot index; 0 = least significant
an  out  8  digit enables, active low, one-hot-zero
seg  out  7  segments {g,f,e,d,c,b,a}, active low
dp  out  1  decimal point, constant 1 (off)
commit  out  1  one-cycle pulse when a frame moves from shadow to active

Behaviour:
- Reset (async) values:
  - shadow and active buffers = all 0; mask = 0; err = 0.
  - scan index = 0; prescaler = 0.
  - an = 8'hFF; seg = 7'h7F; commit = 0; dp = 1.
- Capture (every clock edge):
  - Capture occurs when status != 2'b10 and pos <= 7: shadow[pos] <= data and mask[pos] <= 1.
  - pos >= 8 is ignored. Any input while status == 2'b10 is ignored.
  - A repeated pos overwrites that slot; the mask bit stays set.
- Commit:
  - When mask == 8'hFF at a clock edge: active <= shadow, mask <= 0, and commit = 1 for that single cycle (registered).
  - A capture in the same edge as a commit sets only its own mask bit in the cleared mask. Its data goes to shadow only, not to the committed frame.
  - A partial frame is never displayed. Reset mid-frame discards it.
- Error:
  - err sets on any clock edge with status == 2'b00 and is sticky until reset.
  - Capture and commit continue while err is set, but the display ignores the buffers.
  - err overrides the normal display from the cycle after it sets.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the scan index increments 0..7 and wraps 7 -> 0.
- Outputs (registered, one cycle behind the index and buffers):
  - an = ~(8'b1 << idx).
  - seg = glyph for the selected digit.
  - First valid output is the cycle after reset release: an = 8'hFE, seg = 7'h40.
- Glyph selection:
  - err = 1: digit 3 = E (7'h06), digits 2 and 1 = r (7'h2F), digit 0 = o (7'h23), digits 7..4 blank (7'h7F).
  - Normal: values 0..9 encode as 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex). Values 10..15 are blank.
  - BLANK_LZ = 1: digit i (i >= 1) is blank if active[i] through active[7] are all 0.
- Width rules:
  - Prescaler width = clog2(SCAN_DIV).
  - No arithmetic on data; it is used only as an index.

Test Plan:
- Reset release, SCAN_DIV=4:
  - cycle 1 -> an = FE, seg = 40.
  - every 4 cycles an steps FD, FB, ... 7F, then back to FE.
  - commit never pulses.
- Stream status=01, pos 0..7 with data 3,2,1,0,0,0,0,0 -> commit pulses once the cycle after pos 7. Then, with BLANK_LZ=1:
  - digit 0 = 30, digit 1 = 24, digit 2 = 79.
  - digits 3..7 = 7F.
- Partial frame pos 0..4 then status=10 for 100 cycles -> no commit; display unchanged.
  - Next full frame 9,9,9,9,9,9,9,9 -> all digits = 10.
- Frame with pos 2 written twice (5 then 7) -> committed digit 2 = 78.
  - pos 8..15 inputs have no effect on mask or buffers.
- status=00 for one cycle -> within one cycle the scan shows:
  - digit 3 = 06, digits 2 and 1 = 2F, digit 0 = 23, others 7F.
  - persists through later frames.
  - reset clears it, and the display returns to a single "0".
- Assert reset mid-scan with 4 slots captured -> an = FF immediately (async). After release, a full new frame commits with no stale digits.
